// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: FSM state encoding, requester IDs
// and the supported RAM read-latency range.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    localparam logic ID_PORT0 = 1'b0;
    localparam logic ID_PORT1 = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_rsp_tag_pipe.sv
// Latency-matching shift register of {read valid, requester id}; the tail lines up
// with mem_rdata so the returning word can be steered to the port that issued it.
module rsp_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic push_v,
    input  logic push_id,
    output logic pop_v,
    output logic pop_id,
    output logic any_v
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_lat_check
        $error("rsp_tag_pipe: RD_LAT outside supported range");
    end

    logic [RD_LAT-1:0] v_q, v_d;
    logic [RD_LAT-1:0] id_q, id_d;

    always_comb begin
        v_d     = v_q << 1;
        id_d    = id_q << 1;
        v_d[0]  = push_v;
        id_d[0] = push_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= '0;
            id_q <= '0;
        end else begin
            v_q  <= v_d;
            id_q <= id_d;
        end
    end

    assign pop_v  = v_q[RD_LAT-1];
    assign pop_id = id_q[RD_LAT-1];
    assign any_v  = |v_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port coefficient RAM between the NTT engine (port 0) and the host
// (port 1): round-robin with a burst limit, or fixed port-0 priority with MEM_ARB_PRIO0_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sel,
    output logic              busy
);

    // state  | meaning
    // IDLE   | nobody owns the RAM; next edge picks a requester (one bubble cycle)
    // GRANT0 | port 0 (NTT engine) owns the RAM port
    // GRANT1 | port 1 (host) owns the RAM port

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST - 1);

    arb_state_e    state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          gnt_act, gnt_id, gnt_valid, oth_valid, xfer;
    logic          leave, limit_hit, pick1;
    logic          tail_v, tail_id, rd_any;

    assign gnt_act   = (state_q != IDLE);
    assign gnt_id    = (state_q == GRANT1);
    assign gnt_valid = gnt_id ? req1_valid : req0_valid;
    assign oth_valid = gnt_id ? req0_valid : req1_valid;
    assign xfer      = gnt_act & gnt_valid;

`ifdef MEM_ARB_PRIO0_EN
    // Port 0 is never forced off; only a port-1 burst can be cut short.
    assign pick1     = !req0_valid;
    assign limit_hit = xfer & gnt_id & oth_valid & (burst_q == BURST_LIM);
`else
    logic last_q, last_d;

    assign pick1     = (req0_valid & req1_valid) ? !last_q : req1_valid;
    assign limit_hit = xfer & oth_valid & (burst_q == BURST_LIM);

    always_comb begin
        last_d = last_q;
        if (leave) last_d = gnt_id;
    end

    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        leave   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid | req1_valid) state_d = pick1 ? GRANT1 : GRANT0;
            end
            GRANT0, GRANT1: begin
                if (!gnt_valid) begin
                    leave   = 1'b1;
                    state_d = oth_valid ? (gnt_id ? GRANT0 : GRANT1) : IDLE;
                end else if (limit_hit) begin
                    leave   = 1'b1;
                    state_d = gnt_id ? GRANT0 : GRANT1;
                end else if (burst_q != BURST_LIM) begin
                    burst_d = burst_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (leave) burst_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    // Command fields are forced to zero while idle so nothing leaks onto the RAM bus.
    always_comb begin
        req0_ready = (state_q == GRANT0);
        req1_ready = (state_q == GRANT1);
        sel        = gnt_id;
        mem_en     = xfer;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (gnt_act) begin
            mem_we    = gnt_id ? req1_we    : req0_we;
            mem_addr  = gnt_id ? req1_addr  : req0_addr;
            mem_wdata = gnt_id ? req1_wdata : req0_wdata;
        end
    end

    rsp_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .push_v  (xfer & !mem_we),
        .push_id (gnt_id),
        .pop_v   (tail_v),
        .pop_id  (tail_id),
        .any_v   (rd_any)
    );

    assign rsp0_valid = tail_v & (tail_id == ID_PORT0);
    assign rsp1_valid = tail_v & (tail_id == ID_PORT1);
    assign rsp_rdata  = mem_rdata;
    assign busy       = gnt_act | rd_any;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (RD_LAT=2, MAX_BURST=4); expectations follow
// MEM_ARB_PRIO0_EN when it is defined.
module tb_mem_port_arbiter;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 4;
    localparam int N_RAND    = 3000;

    logic              clk;
    logic              rst;
    logic              req0_valid, req0_we, req1_valid, req1_we;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_wdata, req1_wdata;
    logic              req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic              mem_en, mem_we, sel, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata, rsp_rdata;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid),
        .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .sel(sel), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model with an RD_LAT-deep read pipeline; contents re-seeded on reset.
    logic [DATA_W-1:0] ram [256];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    assign mem_rdata = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
            for (int i = 0; i < 256; i++) ram[i] <= 32'hC0DE_0000 | 32'(i);
        end else begin
            rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : '0;
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                               mem_en, mem_we, sel, busy}), 64'(0));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_data"}, 64'({mem_wdata, rsp_rdata}), 64'(0));
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    endtask

    // Leaves the bench 1 time unit into the first post-reset cycle.
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Expected {ready1, ready0, sel, mem_en} per cycle of the contention scenario;
    // req0 drops valid at cycle 13.
    function automatic logic [3:0] cont_exp(input int c);
`ifdef MEM_ARB_PRIO0_EN
        if (c == 0)  return 4'b0000;
        if (c <= 12) return 4'b0101;
        if (c == 13) return 4'b0100;
        return 4'b1011;
`else
        if (c == 0) return 4'b0000;
        if (c <= 4 || (c >= 9 && c <= 12)) return 4'b0101;
        return 4'b1011;
`endif
    endfunction

    typedef struct packed {
        logic              v0;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        logic              e_rdy0;
        logic              e_en;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
        logic              e_busy;
    } vec_t;

    typedef struct packed {
        int                due;
        logic              port;
        logic [DATA_W-1:0] data;
    } rsp_t;

    vec_t tbl [7];
    rsp_t sb [$];
    rsp_t ent;

    // Reference-model state: current owner (-1 none), transfers in this tenure, last owner.
    int   m_own, m_run, m_last, cyc;
    int   wait_cnt [2];
    int   max_wait;
    logic gen_v [2];
    logic gen_we [2];
    logic [ADDR_W-1:0] gen_a [2];
    logic [DATA_W-1:0] gen_d [2];
    logic acc [2];
    logic e_x, e_r0, e_r1, e_busy, got;
    logic [1:0] e_rsp;
    logic [DATA_W-1:0] e_data;
    int   prob;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", checks);
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 8'h10, 32'hA0, 1'b0, 1'b0, 8'h00, 32'h00, 1'b0};
        tbl[1] = '{1'b1, 8'h10, 32'hA0, 1'b1, 1'b1, 8'h10, 32'hA0, 1'b1};
        tbl[2] = '{1'b1, 8'h11, 32'hA1, 1'b1, 1'b1, 8'h11, 32'hA1, 1'b1};
        tbl[3] = '{1'b1, 8'h12, 32'hA2, 1'b1, 1'b1, 8'h12, 32'hA2, 1'b1};
        tbl[4] = '{1'b1, 8'h13, 32'hA3, 1'b1, 1'b1, 8'h13, 32'hA3, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 32'h00, 1'b1, 1'b0, 8'h00, 32'h00, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 32'h00, 1'b0, 1'b0, 8'h00, 32'h00, 1'b0};

        do_reset();
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;

        // Single requester write burst.
        for (int i = 0; i < 7; i++) begin
            req0_valid = tbl[i].v0;
            req0_we    = tbl[i].v0;
            req0_addr  = tbl[i].a0;
            req0_wdata = tbl[i].d0;
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i),
                64'({req0_ready, req1_ready, mem_en, mem_we, sel, busy}),
                64'({tbl[i].e_rdy0, 1'b0, tbl[i].e_en, tbl[i].e_en, 1'b0, tbl[i].e_busy}));
            chk($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(tbl[i].e_addr));
            chk($sformatf("vec%0d_wdata", i), 64'(mem_wdata), 64'(tbl[i].e_wdata));
            @(posedge clk); #1;
        end

        // Both ports streaming from reset.
        do_reset();
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h20; req0_wdata = 32'h0A0A;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h30; req1_wdata = 32'h0B0B;
        for (int c = 0; c < 15; c++) begin
            if (c == 13) req0_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("cont_c%0d", c), 64'({req1_ready, req0_ready, sel, mem_en}),
                64'(cont_exp(c)));
            @(posedge clk); #1;
        end
        clear_inputs();

        // Port 1 writes 0x1234 to 0x05, then reads it back.
        do_reset();
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h05; req1_wdata = 32'h1234;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (req1_ready) got = 1'b1;
            @(posedge clk); #1;
        end
        chk("rd_wr_grant", 64'(got), 64'(1));
        req1_we = 1'b0;
        @(negedge clk);
        chk("rd_issue", 64'({req1_ready, mem_en, mem_we, mem_addr}), 64'({3'b110, 8'h05}));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("rd_lat1", 64'({rsp0_valid, rsp1_valid}), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_lat2", 64'({rsp0_valid, rsp1_valid, busy}), 64'(3'b011));
        chk("rd_data", 64'(rsp_rdata), 64'(32'h1234));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_after", 64'({rsp0_valid, rsp1_valid, busy}), 64'(0));
        @(posedge clk); #1;

        // Reset with two reads in flight.
        do_reset();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h01;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rd1", 64'({req0_ready, mem_en, mem_we}), 64'(3'b110));
        @(posedge clk); #1;
        req0_addr = 8'h02;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rd2", 64'({mem_en, busy}), 64'(2'b11));
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        check_all_zero("rst_mid");
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_addr = 8'h03;
        req1_valid = 1'b1; req1_addr = 8'h04;
        @(negedge clk);
        chk("rst_idle", 64'({rsp0_valid, rsp1_valid, req0_ready, req1_ready}), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_first_grant", 64'({rsp0_valid, rsp1_valid, req0_ready, req1_ready}),
            64'(4'b0010));
        @(posedge clk); #1;
        clear_inputs();

        // Randomized traffic against the reference model.
        do_reset();
        m_own = -1; m_run = 0; m_last = 1; cyc = 0; max_wait = 0;
        sb.delete();
        for (int p = 0; p < 2; p++) begin
            gen_v[p] = 1'b0; gen_we[p] = 1'b0; gen_a[p] = '0; gen_d[p] = '0;
            wait_cnt[p] = 0;
        end
        for (int n = 0; n < N_RAND; n++) begin
            @(negedge clk);
            e_x = 1'b0;
            if (m_own >= 0) e_x = gen_v[m_own];
            e_r0   = (m_own == 0);
            e_r1   = (m_own == 1);
            e_busy = (m_own >= 0) || (sb.size() > 0);
            chk("rnd_ctl", 64'({req0_ready, req1_ready, sel, mem_en, busy}),
                64'({e_r0, e_r1, e_r1, e_x, e_busy}));
            if (e_x) begin
                chk("rnd_cmd", 64'({mem_we, mem_addr, mem_wdata}),
                    64'({gen_we[m_own], gen_a[m_own], gen_d[m_own]}));
            end
            e_rsp  = 2'b00;
            e_data = '0;
            if (sb.size() > 0) begin
                if (sb[0].due == cyc) begin
                    e_rsp  = sb[0].port ? 2'b01 : 2'b10;
                    e_data = sb[0].data;
                    void'(sb.pop_front());
                end
            end
            chk("rnd_rsp", 64'({rsp0_valid, rsp1_valid}), 64'(e_rsp));
            if (e_rsp != 2'b00) chk("rnd_rdata", 64'(rsp_rdata), 64'(e_data));
            if (e_x && !gen_we[m_own]) begin
                ent.due  = cyc + RD_LAT;
                ent.port = (m_own == 1);
                ent.data = ram[gen_a[m_own]];
                sb.push_back(ent);
            end
            for (int p = 0; p < 2; p++) begin
                acc[p] = gen_v[p] && (m_own == p);
                if (gen_v[p] && !acc[p]) wait_cnt[p]++;
                else wait_cnt[p] = 0;
                if (wait_cnt[p] > max_wait) max_wait = wait_cnt[p];
            end

            @(posedge clk);
            if (m_own < 0) begin
                if (gen_v[0] || gen_v[1]) begin
`ifdef MEM_ARB_PRIO0_EN
                    m_own = gen_v[0] ? 0 : 1;
`else
                    m_own = (gen_v[0] && gen_v[1]) ? (1 - m_last) : (gen_v[0] ? 0 : 1);
`endif
                    m_run = 0;
                end
            end else if (!gen_v[m_own]) begin
                m_last = m_own;
                m_own  = gen_v[1 - m_own] ? (1 - m_own) : -1;
                m_run  = 0;
            end else begin
                m_run++;
`ifdef MEM_ARB_PRIO0_EN
                if (m_own == 1 && gen_v[0] && m_run >= MAX_BURST) begin
`else
                if (gen_v[1 - m_own] && m_run >= MAX_BURST) begin
`endif
                    m_last = m_own;
                    m_own  = 1 - m_own;
                    m_run  = 0;
                end
            end
            cyc++;
            #1;
            prob = ((n / 500) % 2 == 1) ? 90 : 40;
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) gen_v[p] = 1'b0;
                if (!gen_v[p] && n < N_RAND - 20 && $urandom_range(99, 0) < prob) begin
                    gen_v[p]  = 1'b1;
                    gen_we[p] = $urandom_range(1, 0) == 1;
                    gen_a[p]  = 8'($urandom_range(15, 0));
                    gen_d[p]  = $urandom;
                end
            end
            req0_valid = gen_v[0]; req0_we = gen_we[0]; req0_addr = gen_a[0]; req0_wdata = gen_d[0];
            req1_valid = gen_v[1]; req1_we = gen_we[1]; req1_addr = gen_a[1]; req1_wdata = gen_d[1];
        end
        chk("rnd_drain", 64'(sb.size()), 64'(0));
`ifndef MEM_ARB_PRIO0_EN
        chk("rnd_fair", 64'(max_wait <= MAX_BURST + 1), 64'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
